// File: rtl/rv32_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer that owns the PC, bounds memory waits and traps stickily.
// Define RV32_SEQ_PERF_COUNTERS_EN to add the 64-bit cycle_count / instret_count outputs.
module rv32_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          WAIT_LIMIT = 16,
  parameter int          CW         = $clog2(WAIT_LIMIT + 1)
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  output logic        fetch_req,
  output logic [31:0] fetch_address,
  input  logic        fetch_ready,
  input  logic [31:0] fetch_data,
  output logic [31:0] instruction,
  output logic        instruction_valid,
  input  logic        load_enable,
  input  logic        store_enable,
  input  logic        illegal_instruction,
  input  logic        writes_rd,
  input  logic        next_pc_valid,
  input  logic [31:0] next_pc,
  output logic        mem_req,
  input  logic        mem_ready,
  output logic        write_back_enable,
  output logic [31:0] pc,
  output logic        halted,
  output logic        trap,
`ifdef RV32_SEQ_PERF_COUNTERS_EN
  output logic [63:0] cycle_count,
  output logic [63:0] instret_count,
`endif
  output logic [1:0]  trap_cause
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, MEM, WB, TRAP} state_t;

  localparam logic [1:0]    CAUSE_TIMEOUT  = 2'd1;
  localparam logic [1:0]    CAUSE_ILLEGAL  = 2'd2;
  localparam logic [1:0]    CAUSE_MISALIGN = 2'd3;
  localparam logic [CW-1:0] WAIT_LAST      = CW'(WAIT_LIMIT - 1);

  state_t        state;
  state_t        state_next;
  logic [1:0]    cause_next;
  logic [CW-1:0] wait_count;
  logic          wait_expired;
  logic          pc_aligned;
  logic          wb_pending;

  assign pc_aligned    = (pc[1:0] == 2'b00);
  assign wait_expired  = (wait_count == WAIT_LAST);
  assign fetch_address = pc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Ready beats timeout: the expiry check only applies on a not-ready cycle.
  always_comb begin
    state_next = state;
    cause_next = CAUSE_TIMEOUT;
    case (state)
      IDLE:    if (enable) state_next = FETCH;
      FETCH: begin
        if (!pc_aligned) begin
          state_next = TRAP;
          cause_next = CAUSE_MISALIGN;
        end else if (fetch_ready) begin
          state_next = DECODE;
        end else if (wait_expired) begin
          state_next = TRAP;
        end
      end
      DECODE:  state_next = EXECUTE;
      EXECUTE: begin
        if (illegal_instruction) begin
          state_next = TRAP;
          cause_next = CAUSE_ILLEGAL;
        end else if (load_enable || store_enable) begin
          state_next = MEM;
        end else begin
          state_next = WB;
        end
      end
      MEM: begin
        if (mem_ready)         state_next = WB;
        else if (wait_expired) state_next = TRAP;
      end
      WB:      state_next = enable ? FETCH : IDLE;
      TRAP:    state_next = TRAP;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    fetch_req         = 1'b0;
    instruction_valid = 1'b0;
    mem_req           = 1'b0;
    write_back_enable = 1'b0;
    halted            = 1'b0;
    trap              = 1'b0;
    case (state)
      IDLE:    halted = 1'b1;
      FETCH:   fetch_req = pc_aligned;
      DECODE:  instruction_valid = 1'b1;
      MEM:     mem_req = 1'b1;
      WB:      write_back_enable = wb_pending;
      TRAP: begin
        halted = 1'b1;
        trap   = 1'b1;
      end
      default: ;
    endcase
  end

  // Decode class is captured in EXECUTE so the WB strobe stays a pure register decode.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= RESET_PC;
      instruction <= '0;
      wait_count  <= '0;
      wb_pending  <= 1'b0;
      trap_cause  <= '0;
    end else begin
      if ((state == FETCH && pc_aligned && !fetch_ready) || (state == MEM && !mem_ready))
        wait_count <= wait_count + CW'(1);
      else
        wait_count <= '0;
      if (state == FETCH && pc_aligned && fetch_ready) instruction <= fetch_data;
      if (state == EXECUTE) wb_pending <= writes_rd & ~store_enable;
      if (state == WB) pc <= next_pc_valid ? next_pc : pc + 32'd4;
      if (state != TRAP && state_next == TRAP) trap_cause <= cause_next;
    end
  end

`ifdef RV32_SEQ_PERF_COUNTERS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      if (state != IDLE && state != TRAP) cycle_count <= cycle_count + 64'd1;
      if (state == WB) instret_count <= instret_count + 64'd1;
    end
  end
`endif

endmodule
